// File: rtl/seq_detector_param.sv
// Parametrised Moore serial sequence detector with sample enable and a saturating,
// clearable match counter. The next-state logic is built from PATTERN at elaboration.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 OVERLAP = 0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int SW = $clog2(SEQ_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PEN = ~CNT_W'(1);

  typedef enum logic [SW-1:0] {
    S_IDLE  = SW'(0),
    S_MATCH = SW'(SEQ_LEN)
  } state_e;

  generate
    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
      $error("seq_detector_param: SEQ_LEN must be in 2..16");
    end
  endgenerate

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
  function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
    logic [SEQ_LEN:0] s;
    int               best;
    logic             ok;
    best = 0;
    s    = '0;
    for (int j = 0; j <= SEQ_LEN; j++) begin
      if (j < k) s[j] = PATTERN[SEQ_LEN-1-j];
      else if (j == k) s[j] = b;
    end
    for (int l = 1; l <= SEQ_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          if (s[k+1-l+i] != PATTERN[SEQ_LEN-1-i]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] nxt0 [SEQ_LEN+1];
  logic [SW-1:0] nxt1 [SEQ_LEN+1];

  genvar gi;
  generate
    for (gi = 0; gi <= SEQ_LEN; gi++) begin : g_state
      // Without overlap, MATCH restarts exactly like the empty state.
      localparam int            K  = (gi == SEQ_LEN && OVERLAP == 0) ? 0 : gi;
      localparam logic [SW-1:0] N0 = kmp_next(K, 1'b0);
      localparam logic [SW-1:0] N1 = kmp_next(K, 1'b1);
      assign nxt0[gi] = N0;
      assign nxt1[gi] = N1;
    end
  endgenerate

  logic [SW-1:0] state_reg, state_next;
  logic          bad_enc;
  logic          hit;

  generate
    if ((SEQ_LEN + 1) < (1 << SW)) begin : g_gap
      assign bad_enc = (state_reg > S_MATCH);
    end else begin : g_nogap
      assign bad_enc = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    hit        = 1'b0;
    if (bad_enc) begin
      state_next = S_IDLE;
    end else if (en) begin
      state_next = x ? nxt1[state_reg] : nxt0[state_reg];
      hit        = (state_next == S_MATCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  assign z = (state_reg == S_MATCH);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;

  always_comb begin
    cnt_next = cnt_reg;
    sat_next = sat_reg;
    if (clr_cnt) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (hit) begin
      if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
      // Sticky flag rises as soon as the count reaches all-ones.
      if (cnt_reg == CNT_MAX || cnt_reg == CNT_PEN) sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      sat_reg <= sat_next;
    end
  end

  assign match_cnt = cnt_reg;
  assign cnt_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four configurations share one input stream and are
// checked against a history-based reference model through a scoreboard queue.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n, en, x, clr_cnt;
  always #5 clk = ~clk;

  logic       z0, z1, z2, z3;
  logic       s0, s1, s2, s3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  seq_detector_param u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z0), .match_cnt(c0), .cnt_sat(s0)
  );
  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z1), .match_cnt(c1), .cnt_sat(s1)
  );
  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z2), .match_cnt(c2), .cnt_sat(s2)
  );
  seq_detector_param #(.SEQ_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z3), .match_cnt(c3), .cnt_sat(s3)
  );

  logic [3:0] obs_z, obs_s;
  logic [7:0] obs_c [4];
  assign obs_z = {z3, z2, z1, z0};
  assign obs_s = {s3, s2, s1, s0};
  assign obs_c[0] = c0;
  assign obs_c[1] = c1;
  assign obs_c[2] = c2;
  assign obs_c[3] = {6'd0, c3};

  int total = 0;
  int bad   = 0;
  int stepno = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: accepted-bit history since the last restart.
  logic [15:0] mpat [4] = '{16'hA, 16'hA, 16'hF, 16'h3};
  int          mlen [4] = '{4, 4, 4, 2};
  int          mov  [4] = '{0, 1, 1, 1};
  int          mmax [4] = '{255, 255, 255, 3};
  logic [31:0] hist [4];
  int          hlen [4];
  logic        mz   [4];
  int          mcnt [4];
  logic        msat [4];

  typedef struct packed {
    logic [3:0]      z;
    logic [3:0]      sat;
    logic [3:0][7:0] cnt;
  } exp_t;
  exp_t sbq[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0; hlen[i] = 0; mz[i] = 1'b0; mcnt[i] = 0; msat[i] = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic xv, input logic c);
    exp_t ex;
    logic m;
    logic [31:0] mask;
    @(negedge clk);
    en = e; x = xv; clr_cnt = c;
    for (int i = 0; i < 4; i++) begin
      m = 1'b0;
      if (e) begin
        hist[i] = {hist[i][30:0], xv};
        if (hlen[i] < 32) hlen[i]++;
        mask = (32'd1 << mlen[i]) - 32'd1;
        m = (hlen[i] >= mlen[i]) && ((hist[i] & mask) == {16'd0, mpat[i]});
        mz[i] = m;
        if (m && mov[i] == 0) hlen[i] = 0;
      end
      if (c) begin
        mcnt[i] = 0; msat[i] = 1'b0;
      end else if (m) begin
        if (mcnt[i] < mmax[i]) mcnt[i]++;
        if (mcnt[i] == mmax[i]) msat[i] = 1'b1;
      end
      ex.z[i]   = mz[i];
      ex.sat[i] = msat[i];
      ex.cnt[i] = 8'(mcnt[i]);
    end
    sbq.push_back(ex);
    @(posedge clk);
    #1;
    ex = sbq.pop_front();
    stepno++;
    $display("step %0d en=%0b x=%0b clr=%0b z=%b cnt=%0d/%0d/%0d/%0d sat=%b",
             stepno, e, xv, c, obs_z, obs_c[0], obs_c[1], obs_c[2], obs_c[3], obs_s);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s%0d_d%0d_z", stepno, i), 32'(obs_z[i]), 32'(ex.z[i]));
      check($sformatf("s%0d_d%0d_cnt", stepno, i), 32'(obs_c[i]), 32'(ex.cnt[i]));
      check($sformatf("s%0d_d%0d_sat", stepno, i), 32'(obs_s[i]), 32'(ex.sat[i]));
    end
  endtask

  initial begin
    logic [7:0] bits;
    rst_n = 1'b0; en = 1'b0; x = 1'b0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", 32'(z0), 32'd0);
    check("rst_cnt", 32'(c0), 32'd0);
    check("rst_sat", 32'(s0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10101010: non-overlap hits after bits 4 and 8, overlap also after bit 6
    bits = 8'b10101010;
    for (int i = 7; i >= 0; i--) step(1'b1, bits[i], 1'b0);

    // en gating: 1,0 then five gated toggling bits then 1,0
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2 == 0), 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // run of ones: 1111 repeats, 2-bit counter saturates, then clear on a match edge
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // asynchronous reset between edges after 1,0,1
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_z0", 32'(z0), 32'd0);
    check("arst_cnt0", 32'(c0), 32'd0);
    check("arst_z3", 32'(z3), 32'd0);
    check("arst_cnt3", 32'(c3), 32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
